// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage FSM encoding, default datapath width and
// the hard-wired zero register index.
package cpu_pkg;

   localparam int CPU_DATA_W = 16;

   localparam logic [3:0] REG_ZERO = 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_fwd_mux.sv
// WB-to-MEM store-data forwarding mux. Only compiled when MEM_WB_FWD_EN is
// defined; otherwise the hazard unit resolves the store-data hazard by stalling.
`ifdef MEM_WB_FWD_EN
module mem_fwd_mux
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W
) (
   input  logic              i_mem_write,
   input  logic              i_wb_write_reg,
   input  logic [3:0]        i_wb_dst_reg,
   input  logic [3:0]        i_src_reg2,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_wdata
);

   logic w_fwd;

   // A store whose data register is being written by WB this cycle takes the
   // WB result; writes to the zero register are never forwarded.
   assign w_fwd   = i_mem_write & i_wb_write_reg &
                    (i_wb_dst_reg == i_src_reg2) & (i_wb_dst_reg != REG_ZERO);
   assign o_wdata = w_fwd ? i_wb_data : i_wdata;

endmodule
`endif

// File: rtl/pldff.sv
// Parameterised load-enable D flip-flop bank with asynchronous active-low
// reset to zero.
module pldff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   // Load d when enabled, clear on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_q <= '0;
      end else if (i_en) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: turns EX/MEM load/store requests into a one-cycle
// mem_req strobe, stalls the upstream pipeline until mem_valid (or timeout),
// and presents load data / gated write-enable to mem_wb_pipe.
// Optional macro MEM_WB_FWD_EN enables WB-to-MEM store-data forwarding.
//
// Handshake: mem_req is a single-cycle strobe in IDLE; the address/we/wdata
// are registered at that edge and held until the FSM returns to IDLE. The
// memory completes with a one-cycle mem_valid pulse while in BUSY; mem_valid
// in any other state is ignored.
module mem_access_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W  = CPU_DATA_W,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_write_reg,
   input  logic              in_halt,
   input  logic [DATA_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [3:0]        in_src_reg2,
   input  logic              wb_write_reg,
   input  logic [3:0]        wb_dst_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic              stall,
   output logic              out_write_reg,
   output logic [DATA_W-1:0] out_mem_data,
   output logic              mem_err,
   output logic [1:0]        dbg_state
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_t        r_state;
   mem_state_t        w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_data_q;
   logic              r_mem_err;

   logic              w_access;
   logic              w_we;
   logic              w_capture;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_hold_addr;
   logic [DATA_W-1:0] w_hold_wdata;
   logic              w_hold_we;

   // Read wins if the decoder ever raises both; halts never touch memory.
   assign w_access  = (in_mem_read | in_mem_write) & ~in_halt;
   assign w_we      = in_mem_write & ~in_mem_read;
   assign w_capture = (r_state == IDLE) & w_access;

`ifdef MEM_WB_FWD_EN
   mem_fwd_mux #(
      .DATA_W (DATA_W)
   ) u_fwd (
      .i_mem_write    (in_mem_write),
      .i_wb_write_reg (wb_write_reg),
      .i_wb_dst_reg   (wb_dst_reg),
      .i_src_reg2     (in_src_reg2),
      .i_wb_data      (wb_data),
      .i_wdata        (in_wdata),
      .o_wdata        (w_wdata)
   );
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{wb_write_reg, wb_dst_reg, wb_data, in_src_reg2};
   assign w_wdata      = in_wdata;
`endif

   // Request attributes captured at the request edge and held for BUSY/DONE.
   pldff #(
      .WIDTH (2 * DATA_W + 1)
   ) u_hold (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_en    (w_capture),
      .i_d     ({in_addr, w_we, w_wdata}),
      .o_q     ({w_hold_addr, w_hold_we, w_hold_wdata})
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_next        = r_state;
      stall         = 1'b0;
      mem_req       = 1'b0;
      out_write_reg = in_write_reg;
      mem_addr      = in_addr;
      mem_we        = w_access & w_we;
      mem_wdata     = w_wdata;
      unique case (r_state)
         IDLE: begin
            if (w_access) begin
               mem_req       = 1'b1;
               stall         = 1'b1;
               out_write_reg = 1'b0;
               w_next        = BUSY;
            end
         end
         BUSY: begin
            stall         = 1'b1;
            out_write_reg = 1'b0;
            mem_addr      = w_hold_addr;
            mem_we        = w_hold_we;
            mem_wdata     = w_hold_wdata;
            if (mem_valid || (r_cnt == CNT_LAST)) begin
               w_next = DONE;
            end
         end
         DONE: begin
            mem_addr  = w_hold_addr;
            mem_we    = w_hold_we;
            mem_wdata = w_hold_wdata;
            w_next    = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Timeout counter, load-data capture and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_data_q  <= '0;
         r_mem_err <= 1'b0;
      end else begin
         if (w_capture) begin
            r_cnt <= '0;
         end else if (r_state == BUSY) begin
            if (mem_valid) begin
               if (!w_hold_we) begin
                  r_data_q <= mem_rdata;
               end
            end else if (r_cnt == CNT_LAST) begin
               r_data_q  <= '0;
               r_mem_err <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign out_mem_data = r_data_q;
   assign mem_err      = r_mem_err;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage: load/store latency, back-to-back
// loads, timeout, reset during BUSY, halt pass-through and store forwarding.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_write_reg;
  logic        in_halt;
  logic [15:0] in_addr;
  logic [15:0] in_wdata;
  logic [3:0]  in_src_reg2;
  logic        wb_write_reg;
  logic [3:0]  wb_dst_reg;
  logic [15:0] wb_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        stall;
  logic        out_write_reg;
  logic [15:0] out_mem_data;
  logic        mem_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_write_reg  (in_write_reg),
    .in_halt       (in_halt),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_src_reg2   (in_src_reg2),
    .wb_write_reg  (wb_write_reg),
    .wb_dst_reg    (wb_dst_reg),
    .wb_data       (wb_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_valid     (mem_valid),
    .stall         (stall),
    .out_write_reg (out_write_reg),
    .out_mem_data  (out_mem_data),
    .mem_err       (mem_err),
    .dbg_state     (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    in_write_reg = 1'b0;
    in_halt      = 1'b0;
    in_addr      = 16'h0000;
    in_wdata     = 16'h0000;
    in_src_reg2  = 4'd0;
    wb_write_reg = 1'b0;
    wb_dst_reg   = 4'd0;
    wb_data      = 16'h0000;
    mem_rdata    = 16'h0000;
    mem_valid    = 1'b0;
  endtask

  // Memory driver: presents a request (inputs already set by the caller) and
  // answers with mem_valid in the lat-th BUSY cycle (lat < 1: never). Returns
  // in the first non-stalled cycle, counting stall and mem_req cycles.
  task automatic run_access(input int lat, input logic [15:0] rdata,
                            output int n_stall, output int n_req);
    bit done;
    done    = 1'b0;
    n_stall = 0;
    n_req   = 0;
    for (int c = 0; c < 40; c++) begin
      mem_valid = (lat >= 1) && (c == lat);
      mem_rdata = rdata;
      #2;
      if (stall) n_stall++;
      if (mem_req) n_req++;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    mem_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL access_bound: stall still high after 40 cycles, required release");
    end
  endtask

  task automatic test_reset();
    int k;
    k = 0;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    k++;
    if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    k++;
    if (mem_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", mem_err); end
    k++;
    if (out_mem_data !== 16'h0000) begin n_errors++; $display("FAIL reset_data: got %h want 0000", out_mem_data); end
    k++;
    if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    k++;
    n_checks += k;
  endtask

  task automatic test_load();
    int ns, nr;
    in_mem_read  = 1'b1;
    in_write_reg = 1'b1;
    in_addr      = 16'h0040;
    #1;
    n_checks += 3;
    if (mem_addr !== 16'h0040) begin n_errors++; $display("FAIL load_addr: got %h want 0040", mem_addr); end
    if (mem_we !== 1'b0) begin n_errors++; $display("FAIL load_we: got %b want 0", mem_we); end
    if (out_write_reg !== 1'b0) begin n_errors++; $display("FAIL load_wreg_req: got %b want 0", out_write_reg); end
    run_access(3, 16'hBEEF, ns, nr);
    n_checks += 6;
    if (ns != 4) begin n_errors++; $display("FAIL load_stall_cycles: got %0d want 4", ns); end
    if (nr != 1) begin n_errors++; $display("FAIL load_req_pulses: got %0d want 1", nr); end
    if (out_mem_data !== 16'hBEEF) begin n_errors++; $display("FAIL load_data: got %h want beef", out_mem_data); end
    if (out_write_reg !== 1'b1) begin n_errors++; $display("FAIL load_wreg_done: got %b want 1", out_write_reg); end
    if (dbg_state !== 2'd2) begin n_errors++; $display("FAIL load_done_state: got %0d want 2", dbg_state); end
    if (mem_addr !== 16'h0040) begin n_errors++; $display("FAIL load_done_addr: got %h want 0040", mem_addr); end
    tick();
    clear_inputs();
    #1;
    n_checks += 2;
    if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL load_idle_state: got %0d want 0", dbg_state); end
    if (stall !== 1'b0) begin n_errors++; $display("FAIL load_idle_stall: got %b want 0", stall); end
  endtask

  task automatic test_store();
    in_mem_write = 1'b1;
    in_addr      = 16'h0010;
    in_wdata     = 16'h1234;
    #1;
    n_checks += 4;
    if (mem_req !== 1'b1) begin n_errors++; $display("FAIL store_req: got %b want 1", mem_req); end
    if (mem_we !== 1'b1) begin n_errors++; $display("FAIL store_we: got %b want 1", mem_we); end
    if (mem_wdata !== 16'h1234) begin n_errors++; $display("FAIL store_wdata: got %h want 1234", mem_wdata); end
    if (stall !== 1'b1) begin n_errors++; $display("FAIL store_stall0: got %b want 1", stall); end
    tick();
    // Disturb inputs: BUSY must drive the held copies.
    in_wdata  = 16'h0000;
    in_addr   = 16'hFFFF;
    mem_valid = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    n_checks += 5;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL store_stall1: got %b want 1", stall); end
    if (mem_req !== 1'b0) begin n_errors++; $display("FAIL store_req_busy: got %b want 0", mem_req); end
    if (mem_we !== 1'b1) begin n_errors++; $display("FAIL store_we_held: got %b want 1", mem_we); end
    if (mem_wdata !== 16'h1234) begin n_errors++; $display("FAIL store_wdata_held: got %h want 1234", mem_wdata); end
    if (mem_addr !== 16'h0010) begin n_errors++; $display("FAIL store_addr_held: got %h want 0010", mem_addr); end
    tick();
    mem_valid = 1'b0;
    #1;
    n_checks += 3;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL store_done_stall: got %b want 0", stall); end
    if (out_mem_data !== 16'hBEEF) begin n_errors++; $display("FAIL store_data_q: got %h want beef", out_mem_data); end
    if (out_write_reg !== 1'b0) begin n_errors++; $display("FAIL store_wreg: got %b want 0", out_write_reg); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int ns, nr, total_req;
    in_mem_read  = 1'b1;
    in_write_reg = 1'b1;
    in_addr      = 16'h0002;
    run_access(1, 16'hAAAA, ns, nr);
    total_req = nr;
    n_checks += 2;
    if (out_mem_data !== 16'hAAAA) begin n_errors++; $display("FAIL b2b_first: got %h want aaaa", out_mem_data); end
    if (mem_req !== 1'b0) begin n_errors++; $display("FAIL b2b_done_req: got %b want 0", mem_req); end
    tick();
    in_addr = 16'h0004;
    run_access(2, 16'h5555, ns, nr);
    total_req += nr;
    n_checks += 3;
    if (out_mem_data !== 16'h5555) begin n_errors++; $display("FAIL b2b_second: got %h want 5555", out_mem_data); end
    if (total_req != 2) begin n_errors++; $display("FAIL b2b_req_pulses: got %0d want 2", total_req); end
    if (ns != 3) begin n_errors++; $display("FAIL b2b_stall2: got %0d want 3", ns); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    int ns, nr;
    in_mem_read  = 1'b1;
    in_write_reg = 1'b1;
    in_addr      = 16'h0100;
    run_access(0, 16'h7777, ns, nr);
    n_checks += 4;
    if (ns != 16) begin n_errors++; $display("FAIL to_stall_cycles: got %0d want 16", ns); end
    if (mem_err !== 1'b1) begin n_errors++; $display("FAIL to_err: got %b want 1", mem_err); end
    if (out_mem_data !== 16'h0000) begin n_errors++; $display("FAIL to_data: got %h want 0000", out_mem_data); end
    if (stall !== 1'b0) begin n_errors++; $display("FAIL to_stall: got %b want 0", stall); end
    tick();
    clear_inputs();
    in_mem_read = 1'b1;
    in_addr     = 16'h0006;
    run_access(1, 16'h0F0F, ns, nr);
    n_checks += 2;
    if (mem_err !== 1'b1) begin n_errors++; $display("FAIL to_err_sticky: got %b want 1", mem_err); end
    if (out_mem_data !== 16'h0F0F) begin n_errors++; $display("FAIL to_next_data: got %h want 0f0f", out_mem_data); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    int nr;
    in_mem_read = 1'b1;
    in_addr     = 16'h0080;
    tick();
    #1;
    n_checks++;
    if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL rb_busy: got %0d want 1", dbg_state); end
    clear_inputs();
    rst = 1'b0;
    #1;
    n_checks += 4;
    if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL rb_state: got %0d want 0", dbg_state); end
    if (stall !== 1'b0) begin n_errors++; $display("FAIL rb_stall: got %b want 0", stall); end
    if (mem_err !== 1'b0) begin n_errors++; $display("FAIL rb_err: got %b want 0", mem_err); end
    if (out_mem_data !== 16'h0000) begin n_errors++; $display("FAIL rb_data: got %h want 0000", out_mem_data); end
    tick();
    rst       = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 16'h1111;
    nr = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      mem_valid = 1'b0;
      if (mem_req) nr++;
    end
    n_checks += 3;
    if (out_mem_data !== 16'h0000) begin n_errors++; $display("FAIL rb_late_valid: got %h want 0000", out_mem_data); end
    if (nr != 0) begin n_errors++; $display("FAIL rb_no_req: got %0d want 0", nr); end
    if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL rb_idle: got %0d want 0", dbg_state); end
  endtask

  task automatic test_halt();
    in_halt      = 1'b1;
    in_mem_read  = 1'b1;
    in_write_reg = 1'b1;
    #1;
    n_checks += 3;
    if (mem_req !== 1'b0) begin n_errors++; $display("FAIL halt_req: got %b want 0", mem_req); end
    if (stall !== 1'b0) begin n_errors++; $display("FAIL halt_stall: got %b want 0", stall); end
    if (out_write_reg !== 1'b1) begin n_errors++; $display("FAIL halt_wreg: got %b want 1", out_write_reg); end
    tick();
    n_checks++;
    if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL halt_state: got %0d want 0", dbg_state); end
    clear_inputs();
  endtask

  task automatic test_fwd();
    logic [15:0] exp_fwd;
`ifdef MEM_WB_FWD_EN
    exp_fwd = 16'hCAFE;
`else
    exp_fwd = 16'h0000;
`endif
    in_mem_write = 1'b1;
    in_addr      = 16'h0020;
    in_wdata     = 16'h0000;
    in_src_reg2  = 4'd3;
    wb_write_reg = 1'b1;
    wb_dst_reg   = 4'd3;
    wb_data      = 16'hCAFE;
    #1;
    n_checks++;
    if (mem_wdata !== exp_fwd) begin n_errors++; $display("FAIL fwd_match: got %h want %h", mem_wdata, exp_fwd); end
    tick();
    wb_write_reg = 1'b0;
    wb_data      = 16'h0000;
    #1;
    n_checks++;
    if (mem_wdata !== exp_fwd) begin n_errors++; $display("FAIL fwd_held: got %h want %h", mem_wdata, exp_fwd); end
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();
    in_src_reg2  = 4'd0;
    wb_write_reg = 1'b1;
    wb_dst_reg   = 4'd0;
    wb_data      = 16'hCAFE;
    #1;
    n_checks++;
    if (mem_wdata !== 16'h0000) begin n_errors++; $display("FAIL fwd_zero_reg: got %h want 0000", mem_wdata); end
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_load();
    test_store();
    test_back_to_back();
    test_halt();
    test_timeout();
    test_reset_busy();
    test_fwd();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller between the EX/MEM pipeline register and mem_wb_pipe.
- Converts load/store requests into a req/valid handshake with the multi-cycle data memory.
- Stalls upstream pipeline registers while the access is outstanding.
- Presents load data and a valid/gated write-enable for capture by mem_wb_pipe.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT, 15, maximum BUSY cycles before abort; must be >= 1.
- CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_mem_read  in  1  EX/MEM load.
- in_mem_write  in  1  EX/MEM store.
- in_write_reg  in  1  EX/MEM register-write enable.
- in_halt  in  1  EX/MEM halt marker.
- in_addr  in  DATA_W  effective address (ALU out).
- in_wdata  in  DATA_W  store data.
- in_src_reg2  in  4  store-data source register.
- wb_write_reg  in  1  WB-stage write enable (forwarding).
- wb_dst_reg  in  4  WB-stage destination register.
- wb_data  in  DATA_W  WB-stage result.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_valid.
- mem_valid  in  1  memory completion (reads and writes).
- stall  out  1  1 = hold PC, IF/ID, ID/EX, EX/MEM; drive mem_wb_pipe en low.
- out_write_reg  out  1  gated write-enable to mem_wb_pipe.
- out_mem_data  out  DATA_W  load data to mem_wb_pipe.
- mem_err  out  1  sticky timeout error.

Behaviour:
- access = (in_mem_read | in_mem_write) & ~in_halt; read has priority if both are set (decoder never does this).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access=0: stall=0, mem_req=0, out_write_reg=in_write_reg, out_mem_data=data_q.
  - access=1: mem_req=1 (combinational), stall=1, out_write_reg=0; next state BUSY, cnt<=0.
- BUSY:
  - stall=1, mem_req=0; mem_addr/mem_we/mem_wdata held from registered copies captured at the request edge.
  - mem_valid=1: data_q<=mem_rdata (loads only; stores leave data_q unchanged) -> DONE.
  - mem_valid=0 and cnt==TIMEOUT-1: data_q<=0, mem_err<=1 -> DONE.
  - Otherwise cnt<=cnt+1.
- DONE:
  - stall=0, out_write_reg=in_write_reg, out_mem_data=data_q.
  - Upstream advances and mem_wb_pipe captures this edge; next state IDLE unconditionally.
  - No request is re-issued for the same instruction.
- Latency: memory response N cycles after the request edge gives N+1 stall cycles.
- mem_valid is ignored in IDLE and DONE.
- mem_addr/mem_we/mem_wdata:
  - In IDLE, driven combinationally from inputs.
  - In BUSY/DONE, driven from the registered copies.
- Halt instruction: never requests or stalls; passes through as in IDLE.
- Reset (any state, including BUSY): state=IDLE, cnt=0, data_q=0, mem_err=0, held regs=0.
  - Outputs follow IDLE rules; a late mem_valid after reset is ignored.
- mem_err clears only on reset.

Optional Feature:
- Macro: MEM_WB_FWD_EN.
- Defined: store data is forwarded from WB when in_mem_write & wb_write_reg & wb_dst_reg==in_src_reg2 & wb_dst_reg!=0.
  - mem_wdata = wb_data, sampled at the request edge.
- Undefined: mem_wdata = in_wdata always; the hazard unit must stall instead.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - DATA_W default.
  - REG_ZERO=4'd0.
- Held address/data/we registers reuse the existing pldff (WIDTH param, en = state==IDLE & access).
- Sub-module: mem_fwd_mux (forwarding compare + select), compiled only under MEM_WB_FWD_EN.

Test Plan:
- Load, memory latency 3: addr=16'h0040, rdata=16'hBEEF.
  - mem_req one cycle; stall high 4 cycles; DONE gives out_mem_data=16'hBEEF, out_write_reg=1, stall=0.
- Store, latency 1: addr=16'h0010, wdata=16'h1234.
  - mem_we=1, mem_wdata=16'h1234 held through BUSY; stall 2 cycles; data_q unchanged.
- Back-to-back loads (0x0002 -> 16'hAAAA, 0x0004 -> 16'h5555).
  - Exactly two mem_req pulses, separated by the DONE cycle; outputs AAAA then 5555.
- No mem_valid for 15 BUSY cycles.
  - mem_err=1; DONE with out_mem_data=0; stall drops; mem_err stays 1 through later accesses.
- rst low during BUSY, then mem_valid one cycle after release.
  - State IDLE, stall=0, mem_err=0, no capture, no second request unless access is presented again.
- MEM_WB_FWD_EN defined: store with in_src_reg2=4'd3, wb_dst_reg=4'd3, wb_write_reg=1, wb_data=16'hCAFE, in_wdata=16'h0000.
  - mem_wdata=16'hCAFE.
  - Repeat with wb_dst_reg=0: mem_wdata=16'h0000.
